// File: rtl/prog_loader.sv
// Streams a program into instruction memory, launches the CPU and times its run.
// Optional run-cycle counter enabled by defining PROG_LOADER_CYCLE_COUNT_EN.
module prog_loader #(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter int unsigned INSTR_WIDTH   = 9,
  parameter int unsigned LAUNCH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_req,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_WIDTH-1:0] in_data,
  input  logic                   in_last,
  output logic                   im_wr_en,
  output logic [ADDR_WIDTH-1:0]  im_wr_addr,
  output logic [INSTR_WIDTH-1:0] im_wr_data,
  output logic                   cpu_start,
  input  logic                   cpu_done,
  output logic                   busy,
  output logic [ADDR_WIDTH-1:0]  prog_len,
  output logic                   run_done,
  output logic                   overflow_err,
  output logic [15:0]            cycle_count
);

  localparam int unsigned LCNT_W = 4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX    = '1;
  localparam logic [LCNT_W-1:0]     LAUNCH_LAST = LCNT_W'(LAUNCH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_RUN,
    S_FINISH
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [LCNT_W-1:0]       launch_cnt;
  logic                    accept;
  logic                    session_start;

  // in_ready is registered to equal (state == S_LOAD), so it gates acceptance directly
  assign accept        = in_valid & in_ready;
  assign session_start = (state == S_IDLE) & load_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (load_req) state_nxt = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          if (in_last)                  state_nxt = S_LAUNCH;
          else if (wr_addr == ADDR_MAX) state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: if (launch_cnt == LAUNCH_LAST) state_nxt = S_RUN;
      S_RUN:    if (cpu_done) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs are registered from the next state so they align with state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      cpu_start <= 1'b0;
      run_done  <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == S_LOAD);
      busy      <= (state_nxt != S_IDLE);
      cpu_start <= (state_nxt == S_LAUNCH);
      run_done  <= (state_nxt == S_FINISH);
    end
  end

  // Memory write port: one registered write per accepted word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
    end else begin
      im_wr_en <= accept;
      if (accept) begin
        im_wr_addr <= wr_addr;
        im_wr_data <= in_data;
      end
    end
  end

  // Address, length and overflow tracking; address and length never wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_addr      <= '0;
      prog_len     <= '0;
      overflow_err <= 1'b0;
    end else if (session_start) begin
      wr_addr      <= '0;
      prog_len     <= '0;
      overflow_err <= 1'b0;
    end else if (accept) begin
      if (wr_addr != ADDR_MAX)  wr_addr  <= wr_addr + ADDR_WIDTH'(1);
      if (prog_len != ADDR_MAX) prog_len <= prog_len + ADDR_WIDTH'(1);
      if ((wr_addr == ADDR_MAX) && !in_last) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                launch_cnt <= '0;
    else if (state == S_LAUNCH) launch_cnt <= launch_cnt + LCNT_W'(1);
    else                       launch_cnt <= '0;
  end

`ifdef PROG_LOADER_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt;

  // Counts every cycle spent in RUN, including the one that sees cpu_done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          cycle_cnt <= '0;
    else if (session_start)                              cycle_cnt <= '0;
    else if ((state == S_RUN) && (cycle_cnt != 16'hFFFF)) cycle_cnt <= cycle_cnt + 16'd1;
  end

  assign cycle_count = cycle_cnt;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader (ADDR_WIDTH=4 to reach the memory end cheaply).
module tb_prog_loader;
  localparam int unsigned AW = 4;
  localparam int unsigned IW = 9;
  localparam int unsigned LC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_req;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic          im_wr_en;
  logic [AW-1:0] im_wr_addr;
  logic [IW-1:0] im_wr_data;
  logic          cpu_start;
  logic          cpu_done;
  logic          busy;
  logic [AW-1:0] prog_len;
  logic          run_done;
  logic          overflow_err;
  logic [15:0]   cycle_count;

  int n_cmp = 0;
  int n_err = 0;
  int start_cyc = 0;
  int done_pulses = 0;
  logic [IW-1:0] fixed_q[$];

  prog_loader #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .LAUNCH_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
    .cpu_start(cpu_start), .cpu_done(cpu_done), .busy(busy), .prog_len(prog_len),
    .run_done(run_done), .overflow_err(overflow_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (cpu_start) start_cyc++;
      if (run_done)  done_pulses++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Starts a session and streams n words; mode 0 continuous, 1 random gaps, 2 pattern 1,0,0,1
  task automatic do_load(input int n, input bit with_last, input int mode);
    int acc;
    int iter;
    bit v;
    logic [IW-1:0] w;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check_val("prog_len_clr", 32'(prog_len), 32'(0));
    check_val("ovf_clr", 32'(overflow_err), 32'(0));
    check_val("cyc_clr", 32'(cycle_count), 32'(0));
    acc = 0;
    iter = 0;
    while (acc < n && iter < 400) begin
      check_val("in_ready_load", 32'(in_ready), 32'(1));
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = ((iter % 4) == 0) || ((iter % 4) == 3);
      endcase
      w = (acc < fixed_q.size()) ? fixed_q[acc] : IW'($urandom);
      in_valid = v;
      in_data  = w;
      in_last  = v ? (with_last && (acc == n - 1)) : 1'($urandom);
      @(negedge clk);
      check_val("wr_en", 32'(im_wr_en), 32'(v));
      if (v) begin
        check_val("wr_addr", 32'(im_wr_addr), 32'(acc));
        check_val("wr_data", 32'(im_wr_data), 32'(w));
        acc++;
      end
      iter++;
    end
    if (acc < n) check_val("load_timeout", 32'(acc), 32'(n));
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (with_last) check_val("prog_len", 32'(prog_len), 32'(n));
  endtask

  // Launch and run phase: CPU reports done after r idle RUN cycles
  task automatic do_run(input int r, input bit stale, input bit req_in_run);
    int s0;
    int d0;
    int exp_cc;
    s0 = start_cyc;
    d0 = done_pulses;
`ifdef PROG_LOADER_CYCLE_COUNT_EN
    exp_cc = r + 1;
`else
    exp_cc = 0;
`endif
    check_val("cpu_start_on", 32'(cpu_start), 32'(1));
    for (int i = 0; i < int'(LC); i++) begin
      cpu_done = stale;
      in_valid = 1'($urandom);
      @(negedge clk);
      check_val("launch_no_ready", 32'(in_ready), 32'(0));
      check_val("launch_no_wr", 32'(im_wr_en), 32'(0));
    end
    check_val("run_start_off", 32'(cpu_start), 32'(0));
    for (int i = 0; i < r; i++) begin
      cpu_done = 1'b0;
      load_req = req_in_run && (i == r / 2);
      in_valid = 1'($urandom);
      @(negedge clk);
      load_req = 1'b0;
      check_val("run_busy", 32'(busy), 32'(1));
      check_val("run_no_wr", 32'(im_wr_en), 32'(0));
      check_val("run_no_done", 32'(run_done), 32'(0));
    end
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
    in_valid = 1'b0;
    check_val("run_done_pulse", 32'(run_done), 32'(1));
    check_val("finish_busy", 32'(busy), 32'(1));
    @(negedge clk);
    check_val("run_done_low", 32'(run_done), 32'(0));
    check_val("idle_busy", 32'(busy), 32'(0));
    check_val("cycle_count", 32'(cycle_count), 32'(exp_cc));
    check_val("start_cycles", 32'(start_cyc - s0), 32'(LC));
    check_val("done_pulses", 32'(done_pulses - d0), 32'(1));
    @(negedge clk);
    check_val("cycle_hold", 32'(cycle_count), 32'(exp_cc));
  endtask

  initial begin
    reset = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; cpu_done = 1'b0;
    #1;
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_ready", 32'(in_ready), 32'(0));
    check_val("rst_start", 32'(cpu_start), 32'(0));
    check_val("rst_wr_en", 32'(im_wr_en), 32'(0));
    check_val("rst_prog_len", 32'(prog_len), 32'(0));
    check_val("rst_ovf", 32'(overflow_err), 32'(0));
    check_val("rst_cyc", 32'(cycle_count), 32'(0));
    check_val("rst_run_done", 32'(run_done), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("post_rst_busy", 32'(busy), 32'(0));

    // Reset asserted while the write to address 5 is on the port
    do_load(6, 1'b0, 0);
    #1 reset = 1'b0;
    #1;
    check_val("mid_rst_wr_en", 32'(im_wr_en), 32'(0));
    check_val("mid_rst_busy", 32'(busy), 32'(0));
    check_val("mid_rst_prog_len", 32'(prog_len), 32'(0));
    check_val("mid_rst_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    fixed_q = '{9'h1A3, 9'h055, 9'h1FF};
    do_load(3, 1'b1, 0);
    fixed_q.delete();
    do_run(5, 1'b0, 1'b0);

    do_load(2, 1'b1, 2);
    do_run(3, 1'b0, 1'b0);

    cpu_done = 1'b1;
    do_load(4, 1'b1, 1);
    do_run(10, 1'b1, 1'b0);

    do_load(5, 1'b1, 1);
    do_run(6, 1'b0, 1'b1);

    // Sixteen words without in_last fill the memory and abort the session
    begin
      int s0;
      s0 = start_cyc;
      do_load(16, 1'b0, 1);
      check_val("ovf_busy", 32'(busy), 32'(0));
      check_val("ovf_flag", 32'(overflow_err), 32'(1));
      check_val("ovf_ready", 32'(in_ready), 32'(0));
      repeat (3) begin
        in_valid = 1'b1;
        @(negedge clk);
        check_val("ovf_no_wr", 32'(im_wr_en), 32'(0));
        check_val("ovf_sticky", 32'(overflow_err), 32'(1));
      end
      in_valid = 1'b0;
      check_val("ovf_no_start", 32'(start_cyc - s0), 32'(0));
    end

    for (int k = 0; k < 6; k++) begin
      bit stale;
      stale = 1'($urandom);
      cpu_done = stale;
      do_load($urandom_range(1, 15), 1'b1, $urandom_range(0, 2));
      do_run($urandom_range(0, 20), stale, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, 12: instruction-memory address width, equal to the PC width.
REQ-002 Parameter INSTR_WIDTH, 9: instruction word width.
REQ-003 Parameter LAUNCH_CYCLES, 2: number of cycles cpu_start is held high (range 1..15).
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port reset  in  1: asynchronous, active-low reset.
REQ-006 Port load_req  in  1: request to begin a load-and-run session.
REQ-007 Port in_valid  in  1: upstream word valid.
REQ-008 Port in_ready  out  1: loader accepts a word this cycle.
REQ-009 Port in_data  in  INSTR_WIDTH: instruction word.
REQ-010 Port in_last  in  1: marks the final word of the program; sampled with in_data.
REQ-011 Port im_wr_en  out  1: instruction-memory write strobe.
REQ-012 Port im_wr_addr  out  ADDR_WIDTH: instruction-memory write address.
REQ-013 Port im_wr_data  out  INSTR_WIDTH: instruction-memory write data.
REQ-014 Port cpu_start  out  1: drives the CPU start input.
REQ-015 Port cpu_done  in  1: CPU done flag.
REQ-016 Port busy  out  1: high in every state except IDLE.
REQ-017 Port prog_len  out  ADDR_WIDTH: count of words written in the last load.
REQ-018 Port run_done  out  1: one-cycle pulse when the CPU run completes.
REQ-019 Port overflow_err  out  1: sticky flag; program exceeded memory.
REQ-020 Port cycle_count  out  16: number of RUN cycles in the last run.

Function
REQ-021 The FSM SHALL have exactly five states: IDLE, LOAD, LAUNCH, RUN, FINISH.
REQ-022 IDLE: in_ready=0, cpu_start=0; load_req=1 -> LOAD, write address cleared to 0, prog_len cleared, overflow_err cleared.
REQ-023 LOAD: in_ready=1; a word is accepted on in_valid&in_ready.
REQ-024 Accepted word SHALL appear on im_wr_data/im_wr_addr with im_wr_en=1 exactly one cycle after acceptance (registered), one write per accepted word.
REQ-025 Write address SHALL start at 0 and increment by 1 per accepted word; prog_len = words accepted.
REQ-026 Accept with in_last=1 -> LAUNCH.
REQ-027 Accept at address 2^ADDR_WIDTH-1 with in_last=0 SHALL still write that word, set overflow_err, and return to IDLE without launching; the address SHALL NOT wrap.
REQ-028 in_valid=0 in LOAD SHALL stall indefinitely with no write.
REQ-029 LAUNCH: cpu_start=1 for exactly LAUNCH_CYCLES cycles, then RUN; cpu_done ignored (may be stale from a previous run).
REQ-030 RUN: cpu_start=0; cpu_done=1 -> FINISH; cycle_count increments once per RUN cycle, saturating at 16'hFFFF.
REQ-031 FINISH: run_done=1 for one cycle, then IDLE; cycle_count and prog_len hold until the next load_req.
REQ-032 load_req outside IDLE SHALL be ignored.
REQ-033 in_ready SHALL be 0 in LAUNCH, RUN, FINISH; in_valid there is ignored.

Reset
REQ-034 Assertion of reset (low) SHALL immediately force IDLE and zero all outputs and counters, including mid-write (im_wr_en deasserts asynchronously) and mid-run (cpu_start drops).
REQ-035 The first state change after reset deassertion SHALL occur at the next rising clk edge.

Configuration
REQ-036 Macro PROG_LOADER_CYCLE_COUNT_EN defined: cycle_count counter implemented per REQ-030.
REQ-037 Macro PROG_LOADER_CYCLE_COUNT_EN undefined: no counter register; cycle_count tied to 0; all other behaviour unchanged.

Verification
REQ-038 Reset low mid-LOAD at address 5 -> im_wr_en=0 immediately, busy=0, prog_len=0; release, load_req -> writes restart at address 0.
REQ-039 load_req, 3 words 0x1A3, 0x055, 0x1FF (last on third), in_valid continuous -> writes at addr 0,1,2 each one cycle after accept, prog_len=3, cpu_start high 2 cycles.
REQ-040 in_valid toggling 1,0,0,1 during LOAD -> exactly two writes, addresses 0 and 1, no gaps in addresses.
REQ-041 cpu_done held 1 through LAUNCH, then cpu_done=1 asserted 10 cycles into RUN -> launch not skipped, run_done pulses once, cycle_count=11 (macro defined) or 0 (undefined).
REQ-042 ADDR_WIDTH=4, 16 words without in_last -> 16 writes (addr 0..15), overflow_err=1, cpu_start never asserted, state IDLE.
REQ-043 load_req pulsed during RUN -> ignored; session completes normally with run_done pulse.
